// File: rtl/rocc_cmd_queue.sv
// RoCC-style command queue: buffers issued commands in a FIFO, tags them toward
// the accelerator and routes tagged responses back to scoreboard writeback.
module rocc_cmd_queue #(
  parameter  int XLEN          = 64,
  parameter  int DEPTH         = 4,
  parameter  int NTAGS         = 4,
  parameter  int TRANS_ID_BITS = 3,
  localparam int TAG_W         = $clog2(NTAGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  // issue side
  input  logic                     rocc_valid_i,
  output logic                     rocc_ready_o,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [31:0]              instr_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  // accelerator command
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [XLEN-1:0]          cmd_rs1_o,
  output logic [XLEN-1:0]          cmd_rs2_o,
  output logic [31:0]              cmd_instr_o,
  output logic [TAG_W-1:0]         cmd_tag_o,
  // accelerator response
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [TAG_W-1:0]         resp_tag_i,
  input  logic [XLEN-1:0]          resp_data_i,
  // writeback
  output logic                     result_valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     exception_valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]          rs1_q   [DEPTH];
  logic [XLEN-1:0]          rs2_q   [DEPTH];
  logic [31:0]              instr_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] tid_q   [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q;

  logic [NTAGS-1:0]         alloc_q, alloc_d;
  logic [NTAGS-1:0]         killed_q, killed_d;
  logic [TRANS_ID_BITS-1:0] tag_tid_q [NTAGS];

  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic             any_free;
  logic [TAG_W-1:0] free_tag;
  logic             resp_alloc, resp_killed;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  assign rocc_ready_o = !fifo_full && !flush_i;
  assign push         = rocc_valid_i && rocc_ready_o;

  assign cmd_valid_o = !fifo_empty && any_free && !flush_i;
  assign pop         = cmd_valid_o && cmd_ready_i;
  assign cmd_rs1_o   = rs1_q[rd_ptr_q];
  assign cmd_rs2_o   = rs2_q[rd_ptr_q];
  assign cmd_instr_o = instr_q[rd_ptr_q];
  assign cmd_tag_o   = free_tag;

  assign resp_ready_o = 1'b1;
  assign resp_alloc   = alloc_q[resp_tag_i];
  assign resp_killed  = killed_q[resp_tag_i];

  // Scanning downward leaves the lowest free index as the final winner.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    any_free = 1'b0;
    free_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        any_free = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
  end

  // A response frees its tag before a flush kills whatever is still outstanding,
  // so a response landing in the flush cycle is forwarded and not re-killed.
  always_comb begin
    alloc_d  = alloc_q;
    killed_d = killed_q;
    if (resp_valid_i && resp_alloc) begin
      alloc_d[resp_tag_i]  = 1'b0;
      killed_d[resp_tag_i] = 1'b0;
    end
    if (pop) alloc_d[free_tag] = 1'b1;
    if (flush_i) killed_d = alloc_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the payload storage is reset too, so the command outputs read 0 after reset instead of X.
      for (int i = 0; i < DEPTH; i++) begin
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
        instr_q[i] <= '0;
        tid_q[i]   <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        rs1_q[wr_ptr_q]   <= operand_a_i;
        rs2_q[wr_ptr_q]   <= operand_b_i;
        instr_q[wr_ptr_q] <= instr_i;
        tid_q[wr_ptr_q]   <= trans_id_i;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q  <= '0;
      killed_q <= '0;
      for (int i = 0; i < NTAGS; i++) tag_tid_q[i] <= '0;
    end else begin
      alloc_q  <= alloc_d;
      killed_q <= killed_d;
      if (pop) tag_tid_q[free_tag] <= tid_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o    <= 1'b0;
      result_o          <= '0;
      trans_id_o        <= '0;
      exception_valid_o <= 1'b0;
    end else begin
      result_valid_o    <= resp_valid_i && resp_alloc && !resp_killed;
      exception_valid_o <= resp_valid_i && !resp_alloc;
      if (resp_valid_i && resp_alloc && !resp_killed) begin
        result_o   <= resp_data_i;
        trans_id_o <= tag_tid_q[resp_tag_i];
      end
    end
  end

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Directed bench for rocc_cmd_queue: a per-cycle vector table for the basic
// command/response path, then hand sequences for backpressure, tags, flush, reset.
module tb_rocc_cmd_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        rocc_valid_i;
  logic        rocc_ready_o;
  logic [63:0] operand_a_i, operand_b_i;
  logic [31:0] instr_i;
  logic [2:0]  trans_id_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [63:0] cmd_rs1_o, cmd_rs2_o;
  logic [31:0] cmd_instr_o;
  logic [1:0]  cmd_tag_o;
  logic        resp_valid_i;
  logic        resp_ready_o;
  logic [1:0]  resp_tag_i;
  logic [63:0] resp_data_i;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic [2:0]  trans_id_o;
  logic        exception_valid_o;

  int checks = 0;
  int errors = 0;

  rocc_cmd_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .rocc_valid_i(rocc_valid_i), .rocc_ready_o(rocc_ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .instr_i(instr_i), .trans_id_i(trans_id_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_rs1_o(cmd_rs1_o), .cmd_rs2_o(cmd_rs2_o),
    .cmd_instr_o(cmd_instr_o), .cmd_tag_o(cmd_tag_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_tag_i(resp_tag_i), .resp_data_i(resp_data_i),
    .result_valid_o(result_valid_o), .result_o(result_o),
    .trans_id_o(trans_id_o), .exception_valid_o(exception_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rv;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  tid;
    logic        resv;
    logic [1:0]  rtag;
    logic [63:0] rdata;
    logic        e_rrdy;
    logic        e_cval;
    logic [1:0]  e_ctag;
    logic [63:0] e_rs1;
    logic [63:0] e_rs2;
    logic        e_rvld;
    logic [63:0] e_res;
    logic [2:0]  e_rtid;
    logic        e_exc;
  } vec_t;

  function automatic vec_t mk(
    input logic rv, input logic [63:0] a, input logic [63:0] b, input logic [2:0] tid,
    input logic resv, input logic [1:0] rtag, input logic [63:0] rdata,
    input logic e_rrdy, input logic e_cval, input logic [1:0] e_ctag,
    input logic [63:0] e_rs1, input logic [63:0] e_rs2,
    input logic e_rvld, input logic [63:0] e_res, input logic [2:0] e_rtid, input logic e_exc);
    vec_t v;
    v.rv = rv; v.a = a; v.b = b; v.tid = tid;
    v.resv = resv; v.rtag = rtag; v.rdata = rdata;
    v.e_rrdy = e_rrdy; v.e_cval = e_cval; v.e_ctag = e_ctag;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
    v.e_rvld = e_rvld; v.e_res = e_res; v.e_rtid = e_rtid; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush_i = 1'b0; rocc_valid_i = 1'b0; cmd_ready_i = 1'b0; resp_valid_i = 1'b0;
    operand_a_i = '0; operand_b_i = '0; instr_i = '0; trans_id_i = '0;
    resp_tag_i = '0; resp_data_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic push(input logic [63:0] a, input logic [2:0] tid);
    rocc_valid_i = 1'b1; operand_a_i = a; operand_b_i = a + 64'd100;
    instr_i = 32'h0000_000B + 32'(tid); trans_id_i = tid;
  endtask

  task automatic respond(input logic [1:0] tag, input logic [63:0] data);
    resp_valid_i = 1'b1; resp_tag_i = tag; resp_data_i = data;
  endtask

  vec_t vecs [17];

  initial begin
    // Row k: inputs applied in cycle k and the outputs expected in that same cycle.
    vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[1]  = mk(1, 5, 7, 2,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[2]  = mk(0, 0, 0, 0,  0, 0, 0,     1, 1, 0, 5, 7,   0, 0,   0, 0);
    vecs[3]  = mk(0, 0, 0, 0,  1, 0, 12,    1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[4]  = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0, 0,   1, 12,  2, 0);
    vecs[5]  = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[6]  = mk(0, 0, 0, 0,  1, 3, 99,    1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[7]  = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 1);
    vecs[8]  = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[9]  = mk(1, 9, 8, 5,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[10] = mk(0, 0, 0, 0,  0, 0, 0,     1, 1, 0, 9, 8,   0, 0,   0, 0);
    vecs[11] = mk(1, 1, 3, 6,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[12] = mk(0, 0, 0, 0,  0, 0, 0,     1, 1, 1, 1, 3,   0, 0,   0, 0);
    vecs[13] = mk(0, 0, 0, 0,  1, 1, 100,   1, 0, 0, 0, 0,   0, 0,   0, 0);
    vecs[14] = mk(0, 0, 0, 0,  1, 0, 200,   1, 0, 0, 0, 0,   1, 100, 6, 0);
    vecs[15] = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0, 0,   1, 200, 5, 0);
    vecs[16] = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0, 0,   0, 0,   0, 0);

    do_reset();

    // ---------------- table-driven basic path ----------------
    for (int k = 0; k < 17; k++) begin
      @(negedge clk_i);
      idle();
      cmd_ready_i  = 1'b1;
      rocc_valid_i = vecs[k].rv;   operand_a_i = vecs[k].a; operand_b_i = vecs[k].b;
      trans_id_i   = vecs[k].tid;
      resp_valid_i = vecs[k].resv; resp_tag_i = vecs[k].rtag; resp_data_i = vecs[k].rdata;
      #1;
      check($sformatf("v%0d rocc_ready", k), 64'(rocc_ready_o), 64'(vecs[k].e_rrdy));
      check($sformatf("v%0d cmd_valid", k), 64'(cmd_valid_o), 64'(vecs[k].e_cval));
      if (vecs[k].e_cval) begin
        check($sformatf("v%0d cmd_tag", k), 64'(cmd_tag_o), 64'(vecs[k].e_ctag));
        check($sformatf("v%0d cmd_rs1", k), cmd_rs1_o, vecs[k].e_rs1);
        check($sformatf("v%0d cmd_rs2", k), cmd_rs2_o, vecs[k].e_rs2);
      end
      check($sformatf("v%0d result_valid", k), 64'(result_valid_o), 64'(vecs[k].e_rvld));
      if (vecs[k].e_rvld) begin
        check($sformatf("v%0d result", k), result_o, vecs[k].e_res);
        check($sformatf("v%0d trans_id", k), 64'(trans_id_o), 64'(vecs[k].e_rtid));
      end
      check($sformatf("v%0d exception", k), 64'(exception_valid_o), 64'(vecs[k].e_exc));
      check($sformatf("v%0d resp_ready", k), 64'(resp_ready_o), 64'd1);
    end

    // ---------------- backpressure: 5 pushes, 4 fit ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      idle();
      push(64'(10 + i), 3'(i));
      #1;
      check($sformatf("bp push%0d rocc_ready", i), 64'(rocc_ready_o), (i < 4) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      idle();
      cmd_ready_i = 1'b1;
      #1;
      check($sformatf("bp issue%0d cmd_valid", i), 64'(cmd_valid_o), 64'd1);
      check($sformatf("bp issue%0d cmd_tag", i), 64'(cmd_tag_o), 64'(i));
      check($sformatf("bp issue%0d cmd_rs1", i), cmd_rs1_o, 64'(10 + i));
      check($sformatf("bp issue%0d cmd_instr", i), 64'(cmd_instr_o), 64'(32'h0000_000B + i));
    end

    // ---------------- tag exhaustion and out-of-order completion ----------------
    @(negedge clk_i);
    idle();
    cmd_ready_i = 1'b1;
    push(64'd50, 3'd7);
    #1;
    check("exh empty cmd_valid", 64'(cmd_valid_o), 64'd0);
    @(negedge clk_i);
    idle();
    cmd_ready_i = 1'b1;
    #1;
    check("exh no-tag cmd_valid", 64'(cmd_valid_o), 64'd0);
    check("exh rocc_ready", 64'(rocc_ready_o), 64'd1);
    @(negedge clk_i);
    cmd_ready_i = 1'b1;
    respond(2'd2, 64'd77);
    #1;
    check("exh same-cycle reuse blocked", 64'(cmd_valid_o), 64'd0);
    @(negedge clk_i);
    idle();
    cmd_ready_i = 1'b1;
    #1;
    check("exh result_valid", 64'(result_valid_o), 64'd1);
    check("exh result", result_o, 64'd77);
    check("exh trans_id", 64'(trans_id_o), 64'd2);
    check("exh reuse cmd_valid", 64'(cmd_valid_o), 64'd1);
    check("exh reuse cmd_tag", 64'(cmd_tag_o), 64'd2);
    check("exh reuse cmd_rs1", cmd_rs1_o, 64'd50);

    // ---------------- flush: 2 in flight, 2 queued ----------------
    do_reset();
    @(negedge clk_i); idle(); cmd_ready_i = 1'b1; push(64'd1, 3'd1);
    @(negedge clk_i); idle(); cmd_ready_i = 1'b1; push(64'd2, 3'd2);
    @(negedge clk_i); idle(); cmd_ready_i = 1'b1; push(64'd3, 3'd3);
    @(negedge clk_i); idle(); push(64'd4, 3'd4);
    @(negedge clk_i);
    idle();
    flush_i = 1'b1;
    cmd_ready_i = 1'b1;
    push(64'd5, 3'd5);
    #1;
    check("flush rocc_ready", 64'(rocc_ready_o), 64'd0);
    check("flush cmd_valid", 64'(cmd_valid_o), 64'd0);
    @(negedge clk_i);
    idle();
    cmd_ready_i = 1'b1;
    respond(2'd0, 64'hAA);
    #1;
    check("flush fifo empty", 64'(cmd_valid_o), 64'd0);
    check("flush rocc_ready after", 64'(rocc_ready_o), 64'd1);
    @(negedge clk_i);
    idle();
    respond(2'd1, 64'hBB);
    #1;
    check("killed0 result_valid", 64'(result_valid_o), 64'd0);
    check("killed0 exception", 64'(exception_valid_o), 64'd0);
    @(negedge clk_i);
    idle();
    cmd_ready_i = 1'b1;
    push(64'd9, 3'd4);
    #1;
    check("killed1 result_valid", 64'(result_valid_o), 64'd0);
    check("killed1 exception", 64'(exception_valid_o), 64'd0);
    @(negedge clk_i);
    idle();
    cmd_ready_i = 1'b1;
    #1;
    check("post-flush cmd_valid", 64'(cmd_valid_o), 64'd1);
    check("post-flush cmd_tag", 64'(cmd_tag_o), 64'd0);
    check("post-flush cmd_rs1", cmd_rs1_o, 64'd9);

    // ---------------- reset mid-operation ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); idle(); cmd_ready_i = 1'b1; push(64'(20 + i), 3'(i));
    end
    @(negedge clk_i); idle(); cmd_ready_i = 1'b1;
    @(negedge clk_i); idle(); respond(2'd3, 64'h55);
    @(negedge clk_i);
    idle();
    #1;
    check("pre-reset result", result_o, 64'h55);
    check("pre-reset trans_id", 64'(trans_id_o), 64'd3);
    rst_ni = 1'b0;
    #1;
    check("async rst rocc_ready", 64'(rocc_ready_o), 64'd1);
    check("async rst cmd_valid", 64'(cmd_valid_o), 64'd0);
    check("async rst result_valid", 64'(result_valid_o), 64'd0);
    check("async rst result", result_o, 64'd0);
    check("async rst trans_id", 64'(trans_id_o), 64'd0);
    check("async rst exception", 64'(exception_valid_o), 64'd0);
    check("async rst cmd_rs1", cmd_rs1_o, 64'd0);
    check("async rst cmd_rs2", cmd_rs2_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    respond(2'd0, 64'h66);
    @(negedge clk_i);
    idle();
    #1;
    check("post-rst exception", 64'(exception_valid_o), 64'd1);
    check("post-rst result_valid", 64'(result_valid_o), 64'd0);
    @(negedge clk_i);
    #1;
    check("post-rst exception pulse", 64'(exception_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
